// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants.
// RESET_PC default, ADEL exception code and the IF/ID bundle layout.
package if_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
    localparam logic [4:0]  EXC_ADEL     = 5'h04;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

endpackage

// File: rtl/if_stage_if.sv
// SRAM-like instruction bus: request/addr_ok/data_ok.
// Master is the fetch stage, slave is the memory side.
interface if_stage_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, single outstanding bus request,
// one-entry output buffer, redirects with stale-response discard.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.master  bus,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        valid_out,
    input  logic        allow_out,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adel
);

    localparam logic [2:0] S_REQ    = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_FULL   = 3'd2;
    localparam logic [2:0] S_CANCEL = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic [31:0] buf_inst;
    logic        aligned;
    logic        fire;
    logic        avail;
    logic        xfer;
    if_id_t      item;

    assign aligned       = (pc[1:0] == 2'b00);
    assign bus.inst_req  = (state == S_REQ) && aligned;
    assign bus.inst_addr = pc;
    assign fire          = bus.inst_req && bus.inst_addr_ok;

    always_comb begin
        avail = 1'b0;
        item  = '{fetch_pc, buf_inst, 1'b0};
        case (state)
            S_REQ: begin
                if (!aligned) begin
                    avail = 1'b1;
                    item  = '{pc, 32'h0, 1'b1};
                end
            end
            S_WAIT: begin
                avail     = bus.inst_data_ok;
                item.inst = bus.inst_rdata;
            end
            S_FULL:  avail = 1'b1;
            default: avail = 1'b0;
        endcase
    end

    // A redirect kills whatever is presented in the same cycle.
    assign valid_out = avail && !redirect_valid;
    assign xfer      = valid_out && allow_out;
    assign {out_pc, out_inst, out_adel} = item;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            fetch_pc <= 32'h0;
            buf_inst <= 32'h0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            case (state)
                S_REQ:    state <= fire ? S_CANCEL : S_REQ;
                S_WAIT,
                S_CANCEL: state <= bus.inst_data_ok ? S_REQ : S_CANCEL;
                default:  state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (fire) begin
                        fetch_pc <= pc;
                        pc       <= pc + 32'd4;
                        state    <= S_WAIT;
                    end else if (xfer) begin
                        state <= S_HALT;
                    end
                end
                S_WAIT: begin
                    if (bus.inst_data_ok) begin
                        if (allow_out) begin
                            state <= S_REQ;
                        end else begin
                            buf_inst <= bus.inst_rdata;
                            state    <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (allow_out) state <= S_REQ;
                end
                S_CANCEL: begin
                    if (bus.inst_data_ok) state <= S_REQ;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: random bus/redirect/backpressure traffic
// against a program-order fetch model plus directed corner cases.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_out;
    logic        allow_out;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;

    if_stage_if bus ();

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .valid_out      (valid_out),
        .allow_out      (allow_out),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_adel       (out_adel)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory-side and program-order model state
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_dly;
    logic [31:0] exp_pc;
    bit          halted;
    bit          hold_prev;
    logic [65:0] hold_val;
    int          cyc;
    logic [31:0] xq[$];
    int          xc[$];

    // Traffic knobs
    int          p_aok;
    int          p_allow;
    int          p_redir;
    int          min_dly;
    int          max_dly;
    bit          force_redir;
    logic [31:0] force_pc;

    task automatic chk(input string tag, input logic [65:0] got,
                       input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2402_0001;
    endfunction

    function automatic logic [31:0] rand_target();
        int r;
        logic [31:0] v;
        r = $urandom_range(15);
        v = $urandom;
        if (r == 0) return v;
        if (r == 1) return 32'hFFFF_FFFC;
        return v & 32'hFFFF_FFFC;
    endfunction

    task automatic cycle();
        logic exp_adel;
        bus.inst_addr_ok = ($urandom_range(99) < p_aok);
        bus.inst_data_ok = pend && (pend_dly == 0);
        bus.inst_rdata   = bus.inst_data_ok ? mem(pend_addr) : $urandom;
        allow_out        = ($urandom_range(99) < p_allow);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(99) < p_redir);
            redirect_pc    = rand_target();
        end
        @(negedge clk);
        chk("one_outstanding", bus.inst_req & pend, 0);
        if (halted)
            chk("halt_idle", {valid_out, bus.inst_req}, 0);
        if (redirect_valid)
            chk("redir_kills_valid", valid_out, 0);
        if (hold_prev && !redirect_valid)
            chk("hold_stable", {valid_out, out_pc, out_inst, out_adel},
                hold_val);
        if (valid_out && allow_out) begin
            exp_adel = (exp_pc[1:0] != 2'b00);
            chk("xfer_pc", out_pc, exp_pc);
            chk("xfer_inst", out_inst, exp_adel ? 32'h0 : mem(exp_pc));
            chk("xfer_adel", out_adel, exp_adel);
            xq.push_back(out_pc);
            xc.push_back(cyc);
            if (exp_adel) halted = 1'b1;
            exp_pc = exp_pc + 32'd4;
        end
        hold_prev = valid_out && !allow_out;
        hold_val  = {valid_out, out_pc, out_inst, out_adel};
        if (redirect_valid) begin
            exp_pc = redirect_pc;
            halted = 1'b0;
        end
        if (bus.inst_data_ok) pend = 1'b0;
        else if (pend) pend_dly--;
        if (bus.inst_req && bus.inst_addr_ok) begin
            pend      = 1'b1;
            pend_addr = bus.inst_addr;
            pend_dly  = $urandom_range(max_dly, min_dly);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_pend(input bit want);
        for (int i = 0; i < 20; i++) begin
            if (pend == want) break;
            cycle();
        end
        chk("wait_bus_timeout", pend, want);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        allow_out        = 1'b0;
        pend             = 1'b0;
        halted           = 1'b0;
        hold_prev        = 1'b0;
        exp_pc           = DEF_RESET_PC;
        @(negedge clk);
        chk("rst_req", bus.inst_req, 1);
        chk("rst_addr", bus.inst_addr, DEF_RESET_PC);
        chk("rst_valid", valid_out, 0);
        chk("rst_adel", out_adel, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc = 0;
        force_redir = 1'b0;
        force_pc = 32'h0;
        p_aok = 100; p_allow = 100; p_redir = 0;
        min_dly = 0; max_dly = 0;
        #1;
        do_reset();

        // back-to-back fetch, one per two cycles
        run(6);
        chk("seq_count", xq.size(), 3);
        chk("seq_pc0", xq[0], 32'hBFC0_0000);
        chk("seq_pc1", xq[1], 32'hBFC0_0004);
        chk("seq_pc2", xq[2], 32'hBFC0_0008);
        chk("seq_gap", xc[1] - xc[0], 2);

        // downstream stall holds the buffered item
        xq.delete();
        p_allow = 0;
        run(5);
        chk("stall_noxfer", xq.size(), 0);
        chk("stall_valid", valid_out, 1);
        p_allow = 100;
        run(4);
        chk("stall_release", xq.size() >= 1, 1);

        // redirect while waiting for data
        min_dly = 2; max_dly = 2;
        wait_pend(1);
        xq.delete();
        force_redir = 1'b1; force_pc = 32'h8000_1000;
        run(10);
        chk("wait_redir_pc0", xq[0], 32'h8000_1000);
        chk("wait_redir_pc1", xq[1], 32'h8000_1004);

        // redirect coincident with addr_ok
        do_reset();
        min_dly = 1; max_dly = 1;
        wait_pend(1);
        wait_pend(0);
        xq.delete();
        force_redir = 1'b1; force_pc = 32'h8000_1000;
        run(10);
        chk("aok_redir_pc0", xq[0], 32'h8000_1000);
        chk("aok_redir_pc1", xq[1], 32'h8000_1004);

        // misaligned redirect -> ADEL, then idle until redirect
        wait_pend(1);
        wait_pend(0);
        xq.delete();
        p_aok = 0; p_allow = 0;
        force_redir = 1'b1; force_pc = 32'h8000_0002;
        cycle();
        redirect_valid = 1'b0;
        #1;
        chk("adel_req", bus.inst_req, 0);
        chk("adel_valid", valid_out, 1);
        chk("adel_flag", out_adel, 1);
        chk("adel_pc", out_pc, 32'h8000_0002);
        chk("adel_inst", out_inst, 0);
        p_aok = 100; p_allow = 100;
        run(6);
        chk("adel_count", xq.size(), 1);
        force_redir = 1'b1; force_pc = 32'h8000_0180;
        run(6);
        chk("adel_resume", xq[1], 32'h8000_0180);

        // pc wraps past the top of the address space
        xq.delete();
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
        run(12);
        chk("wrap_pc0", xq[0], 32'hFFFF_FFFC);
        chk("wrap_pc1", xq[1], 32'h0000_0000);

        // reset in the middle of a fetch
        wait_pend(1);
        do_reset();
        xq.delete();
        run(6);
        chk("rst_mid_pc0", xq[0], DEF_RESET_PC);

        // random traffic
        xq.delete();
        p_aok = 60; p_allow = 70; p_redir = 8;
        min_dly = 0; max_dly = 3;
        run(3000);
        chk("rand_progress", xq.size() > 100, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
